// File: rtl/viterbi_acs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_acs_scheduler
//  Description : Sequencer for a rate-1/2, K=3 (4-state) Viterbi decoder.
//                Time-multiplexes one shared ACS unit over the four trellis
//                states, tracks the minimum new path metric for
//                normalisation, flips the ping-pong metric banks, addresses
//                the circular survivor memory and launches traceback every
//                TB_DEPTH symbols and at end of frame.
//  Revision    : 1.0  initial release
// ============================================================================
module viterbi_acs_scheduler #(
    parameter int  PM_W     = 8,
    parameter int  TB_DEPTH = 16,
    localparam int c_AW     = $clog2(2*TB_DEPTH),
    localparam int c_LW     = $clog2(TB_DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    input  logic [1:0]        i_sym_data,
    input  logic              i_flush,
    output logic              o_acs_en,
    output logic [1:0]        o_acs_state,
    output logic [1:0]        o_acs_sym,
    input  logic [PM_W-1:0]   i_acs_pm_new,
    output logic              o_pm_rd_bank,
    output logic              o_pm_init,
    output logic [PM_W-1:0]   o_norm_sub,
    output logic              o_surv_wr_en,
    output logic [c_AW-1:0]   o_surv_waddr,
    output logic              o_tb_start,
    output logic [c_AW-1:0]   o_tb_addr,
    output logic [c_LW-1:0]   o_tb_len,
    output logic              o_tb_final,
    input  logic              i_tb_busy
);

    localparam logic [c_AW-1:0] c_WADDR_MAX = c_AW'(2*TB_DEPTH-1);
    localparam logic [c_LW-1:0] c_TB_LEN    = c_LW'(TB_DEPTH);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACS0   = 3'd2,
        S_ACS1   = 3'd3,
        S_ACS2   = 3'd4,
        S_ACS3   = 3'd5,
        S_UPDATE = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_accept;
    logic              w_launch;
    logic              w_launch_final;

    logic              r_pending;
    logic [c_LW-1:0]   r_sym_cnt;
    logic [c_LW-1:0]   w_sym_cnt_inc;
    logic [PM_W-1:0]   r_min;
    logic [1:0]        r_acs_sym;
    logic              r_pm_rd_bank;
    logic [PM_W-1:0]   r_norm_sub;
    logic [c_AW-1:0]   r_surv_waddr;
    logic              r_tb_start;
    logic [c_AW-1:0]   r_tb_addr;
    logic [c_LW-1:0]   r_tb_len;
    logic              r_tb_final;

    assign w_sym_cnt_inc = r_sym_cnt + 1'b1;

    assign o_acs_sym    = r_acs_sym;
    assign o_pm_rd_bank = r_pm_rd_bank;
    assign o_norm_sub   = r_norm_sub;
    assign o_surv_waddr = r_surv_waddr;
    assign o_tb_start   = r_tb_start;
    assign o_tb_addr    = r_tb_addr;
    assign o_tb_len     = r_tb_len;
    assign o_tb_final   = r_tb_final;

    // State register; reset aborts any symbol in flight and returns to INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, handshake, launch decisions and per-state strobes
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_launch       = 1'b0;
        w_launch_final = 1'b0;
        o_sym_ready    = 1'b0;
        o_acs_en       = 1'b0;
        o_acs_state    = 2'd0;
        o_surv_wr_en   = 1'b0;
        o_pm_init      = 1'b0;
        case (r_state)
            S_INIT: begin
                o_pm_init = 1'b1;
                w_next    = S_IDLE;
            end
            S_IDLE: begin
                if (i_flush) begin
                    // End of frame: drain whatever is left once traceback is free
                    if (!i_tb_busy) begin
                        w_next = S_INIT;
                        if (r_pending || (r_sym_cnt != '0)) begin
                            w_launch       = 1'b1;
                            w_launch_final = 1'b1;
                        end
                    end
                end else if (r_pending) begin
                    if (!i_tb_busy) begin
                        w_launch = 1'b1;
                    end
                end else begin
                    o_sym_ready = 1'b1;
                    if (i_sym_valid) begin
                        w_accept = 1'b1;
                        w_next   = S_ACS0;
                    end
                end
            end
            S_ACS0: begin
                o_acs_en     = 1'b1;
                o_surv_wr_en = 1'b1;
                o_acs_state  = 2'd0;
                w_next       = S_ACS1;
            end
            S_ACS1: begin
                o_acs_en     = 1'b1;
                o_surv_wr_en = 1'b1;
                o_acs_state  = 2'd1;
                w_next       = S_ACS2;
            end
            S_ACS2: begin
                o_acs_en     = 1'b1;
                o_surv_wr_en = 1'b1;
                o_acs_state  = 2'd2;
                w_next       = S_ACS3;
            end
            S_ACS3: begin
                o_acs_en     = 1'b1;
                o_surv_wr_en = 1'b1;
                o_acs_state  = 2'd3;
                w_next       = S_UPDATE;
            end
            S_UPDATE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    // Symbol latch for the branch-metric computation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acs_sym <= 2'd0;
        end else if (w_accept) begin
            r_acs_sym <= i_sym_data;
        end
    end

    // Running unsigned minimum of new metrics; strict compare keeps the earlier value on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '0;
        end else begin
            case (r_state)
                S_INIT: r_min <= '0;
                S_ACS0: r_min <= i_acs_pm_new;
                S_ACS1, S_ACS2, S_ACS3: begin
                    if (i_acs_pm_new < r_min) begin
                        r_min <= i_acs_pm_new;
                    end
                end
                default: r_min <= r_min;
            endcase
        end
    end

    // Per-symbol bookkeeping: bank flip, normalisation, survivor pointer, window count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pm_rd_bank <= 1'b0;
            r_norm_sub   <= '0;
            r_surv_waddr <= '0;
            r_sym_cnt    <= '0;
            r_pending    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_pm_rd_bank <= 1'b0;
                    r_norm_sub   <= '0;
                    r_surv_waddr <= '0;
                    r_sym_cnt    <= '0;
                    r_pending    <= 1'b0;
                end
                S_UPDATE: begin
                    r_norm_sub   <= r_min;
                    r_pm_rd_bank <= ~r_pm_rd_bank;
                    r_surv_waddr <= (r_surv_waddr == c_WADDR_MAX) ? '0
                                                                   : r_surv_waddr + 1'b1;
                    r_sym_cnt    <= w_sym_cnt_inc;
                    if (w_sym_cnt_inc == c_TB_LEN) begin
                        r_pending <= 1'b1;
                    end
                end
                S_IDLE: begin
                    // A mid-frame launch opens a fresh window
                    if (w_launch && !w_launch_final) begin
                        r_pending <= 1'b0;
                        r_sym_cnt <= '0;
                    end
                end
                default: begin
                    r_pending <= r_pending;
                end
            endcase
        end
    end

    // Traceback launch registers; address and length hold until the next launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tb_start <= 1'b0;
            r_tb_addr  <= '0;
            r_tb_len   <= '0;
            r_tb_final <= 1'b0;
        end else begin
            r_tb_start <= w_launch;
            if (w_launch) begin
                r_tb_addr  <= (r_surv_waddr == '0) ? c_WADDR_MAX : r_surv_waddr - 1'b1;
                r_tb_len   <= r_pending ? c_TB_LEN : r_sym_cnt;
                r_tb_final <= w_launch_final;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_viterbi_acs_scheduler
//  Description : Self-checking bench for viterbi_acs_scheduler with a
//                symbol-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_viterbi_acs_scheduler;

    localparam int PM_W     = 8;
    localparam int TB_DEPTH = 16;
    localparam int NSLOT    = 2*TB_DEPTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_sym_valid;
    logic            o_sym_ready;
    logic [1:0]      i_sym_data;
    logic            i_flush;
    logic            o_acs_en;
    logic [1:0]      o_acs_state;
    logic [1:0]      o_acs_sym;
    logic [PM_W-1:0] i_acs_pm_new;
    logic            o_pm_rd_bank;
    logic            o_pm_init;
    logic [PM_W-1:0] o_norm_sub;
    logic            o_surv_wr_en;
    logic [4:0]      o_surv_waddr;
    logic            o_tb_start;
    logic [4:0]      o_tb_addr;
    logic [4:0]      o_tb_len;
    logic            o_tb_final;
    logic            i_tb_busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: counts of symbols, not RTL registers
    int exp_waddr;
    int exp_bank;
    int exp_norm;
    int exp_cnt;

    viterbi_acs_scheduler #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sym_valid  (i_sym_valid),
        .o_sym_ready  (o_sym_ready),
        .i_sym_data   (i_sym_data),
        .i_flush      (i_flush),
        .o_acs_en     (o_acs_en),
        .o_acs_state  (o_acs_state),
        .o_acs_sym    (o_acs_sym),
        .i_acs_pm_new (i_acs_pm_new),
        .o_pm_rd_bank (o_pm_rd_bank),
        .o_pm_init    (o_pm_init),
        .o_norm_sub   (o_norm_sub),
        .o_surv_wr_en (o_surv_wr_en),
        .o_surv_waddr (o_surv_waddr),
        .o_tb_start   (o_tb_start),
        .o_tb_addr    (o_tb_addr),
        .o_tb_len     (o_tb_len),
        .o_tb_final   (o_tb_final),
        .i_tb_busy    (i_tb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_waddr = 0;
        exp_bank  = 0;
        exp_norm  = 0;
        exp_cnt   = 0;
    endtask

    // Push one symbol through the scheduler and check it against the model
    task automatic send_sym(input logic [1:0] d, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] pm [4];
        int mn;
        int waited;
        pm[0] = p0; pm[1] = p1; pm[2] = p2; pm[3] = p3;
        waited = 0;
        while (!o_sym_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(o_sym_ready), 1);
        i_sym_valid = 1'b1;
        i_sym_data  = d;
        @(negedge clk);
        i_sym_valid = 1'b0;
        i_sym_data  = 2'($urandom);
        for (int n = 0; n < 4; n++) begin
            chk("acs_en",     32'(o_acs_en), 1);
            chk("acs_state",  32'(o_acs_state), n);
            chk("surv_wr_en", 32'(o_surv_wr_en), 1);
            chk("acs_sym",    32'(o_acs_sym), 32'(d));
            chk("busy_ready", 32'(o_sym_ready), 0);
            i_acs_pm_new = pm[n];
            @(negedge clk);
        end
        chk("update_acs_en", 32'(o_acs_en), 0);
        i_acs_pm_new = 8'($urandom);
        @(negedge clk);
        mn = 32'(pm[0]);
        for (int n = 1; n < 4; n++) begin
            if (32'(pm[n]) < mn) mn = 32'(pm[n]);
        end
        exp_norm  = mn;
        exp_bank  = exp_bank ^ 1;
        exp_waddr = (exp_waddr + 1) % NSLOT;
        exp_cnt   = exp_cnt + 1;
        chk("norm_sub",   32'(o_norm_sub), exp_norm);
        chk("pm_rd_bank", 32'(o_pm_rd_bank), exp_bank);
        chk("surv_waddr", 32'(o_surv_waddr), exp_waddr);
        chk("ready_after", 32'(o_sym_ready), (exp_cnt == TB_DEPTH) ? 0 : 1);
    endtask

    task automatic send_rand();
        send_sym(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Wait (bounded) for a traceback launch and check its fields and pulse width
    task automatic expect_launch(input string tag, input int addr, input int len, input int fin);
        int w;
        w = 0;
        while (!o_tb_start && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_start"}, 32'(o_tb_start), 1);
        chk({tag, "_addr"},  32'(o_tb_addr), addr);
        chk({tag, "_len"},   32'(o_tb_len), len);
        chk({tag, "_final"}, 32'(o_tb_final), fin);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(o_tb_start), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_sym_valid  = 1'b0;
        i_sym_data   = 2'd0;
        i_flush      = 1'b0;
        i_acs_pm_new = '0;
        i_tb_busy    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pm_init",  32'(o_pm_init), 1);
        chk("rst_acs_en",   32'(o_acs_en), 0);
        chk("rst_ready",    32'(o_sym_ready), 0);
        chk("rst_tb_start", 32'(o_tb_start), 0);
        chk("rst_waddr",    32'(o_surv_waddr), 0);
        chk("rst_norm",     32'(o_norm_sub), 0);
        chk("rst_bank",     32'(o_pm_rd_bank), 0);
        chk("rst_tb_len",   32'(o_tb_len), 0);

        // Release: exactly one INIT cycle
        rst_n = 1'b1;
        #1;
        chk("init_pm_init", 32'(o_pm_init), 1);
        @(negedge clk);
        chk("idle_pm_init", 32'(o_pm_init), 0);
        chk("idle_ready",   32'(o_sym_ready), 1);
        chk("idle_tb_addr", 32'(o_tb_addr), 0);

        // Directed first symbol with a tie in the minimum
        send_sym(2'b11, 8'd9, 8'd4, 8'd4, 8'd7);
        chk("norm_9447",  32'(o_norm_sub), 4);
        chk("waddr_one",  32'(o_surv_waddr), 1);

        // Fill the first window
        for (int i = 1; i < TB_DEPTH; i++) send_rand();
        expect_launch("tb16", (exp_waddr + NSLOT - 1) % NSLOT, TB_DEPTH, 0);
        exp_cnt = 0;

        // Second window, with traceback busy at the window end
        for (int i = 1; i < TB_DEPTH; i++) send_rand();
        i_tb_busy = 1'b1;
        send_rand();
        chk("waddr_wrap", 32'(o_surv_waddr), 0);
        for (int i = 0; i < 10; i++) begin
            chk("busy_hold_ready", 32'(o_sym_ready), 0);
            chk("busy_hold_start", 32'(o_tb_start), 0);
            @(negedge clk);
        end
        i_tb_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_start", 32'(o_tb_start), 1);
        expect_launch("tb32", 31, TB_DEPTH, 0);
        exp_cnt = 0;

        // Partial frame then flush
        for (int i = 0; i < 5; i++) send_rand();
        i_flush = 1'b1;
        @(negedge clk);
        chk("flush_start",   32'(o_tb_start), 1);
        chk("flush_len",     32'(o_tb_len), 5);
        chk("flush_final",   32'(o_tb_final), 1);
        chk("flush_addr",    32'(o_tb_addr), (exp_waddr + NSLOT - 1) % NSLOT);
        chk("flush_pm_init", 32'(o_pm_init), 1);
        chk("flush_ready",   32'(o_sym_ready), 0);
        i_flush = 1'b0;
        @(negedge clk);
        model_reset();
        chk("flush_pulse",   32'(o_tb_start), 0);
        chk("flush_pm_done", 32'(o_pm_init), 0);
        chk("flush_waddr",   32'(o_surv_waddr), 0);
        chk("flush_bank",    32'(o_pm_rd_bank), 0);
        chk("flush_norm",    32'(o_norm_sub), 0);
        chk("flush_ready2",  32'(o_sym_ready), 1);

        // Flush with nothing to decode
        i_flush = 1'b1;
        @(negedge clk);
        chk("empty_flush_start",   32'(o_tb_start), 0);
        chk("empty_flush_pm_init", 32'(o_pm_init), 1);
        i_flush = 1'b0;
        @(negedge clk);
        chk("empty_flush_pm_done", 32'(o_pm_init), 0);
        chk("empty_flush_ready",   32'(o_sym_ready), 1);

        // Reset in the middle of a symbol
        send_rand();
        i_sym_valid = 1'b1;
        i_sym_data  = 2'b10;
        @(negedge clk);
        i_sym_valid = 1'b0;
        i_acs_pm_new = 8'd20;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_state", 32'(o_acs_state), 2);
        rst_n = 1'b0;
        #1;
        chk("abort_acs_en",  32'(o_acs_en), 0);
        chk("abort_state",   32'(o_acs_state), 0);
        chk("abort_wr_en",   32'(o_surv_wr_en), 0);
        chk("abort_pm_init", 32'(o_pm_init), 1);
        chk("abort_waddr",   32'(o_surv_waddr), 0);
        chk("abort_bank",    32'(o_pm_rd_bank), 0);
        chk("abort_norm",    32'(o_norm_sub), 0);
        chk("abort_start",   32'(o_tb_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        chk("restart_pm_init", 32'(o_pm_init), 0);
        chk("restart_ready",   32'(o_sym_ready), 1);
        send_rand();
        chk("restart_waddr", 32'(o_surv_waddr), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
